// File: rtl/fpga_debug_pkg.sv
// Shared constants, line FSM state and message formatting helpers for the FPGA debug monitors.
package fpga_debug_pkg;

    localparam int unsigned DBG_MSG_LEN = 21;
    localparam int unsigned FRAME_BITS  = 10;

    localparam logic [7:0] ASCII_P          = 8'h50;
    localparam logic [7:0] ASCII_I          = 8'h49;
    localparam logic [7:0] ASCII_SP         = 8'h20;
    localparam logic [7:0] ASCII_CR         = 8'h0D;
    localparam logic [7:0] ASCII_LF         = 8'h0A;
    localparam logic [7:0] ASCII_0          = 8'h30;
    localparam logic [7:0] ASCII_A_MINUS_10 = 8'h37;

    typedef enum logic [0:0] {StIdle, StSend} line_state_e;

    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        return (nib < 4'd10) ? (ASCII_0 + {4'd0, nib}) : (ASCII_A_MINUS_10 + {4'd0, nib});
    endfunction

    // Byte at position idx of "Pxxxxxxxx Ixxxxxxxx\r\n", most significant nibble first.
    function automatic logic [7:0] msg_byte(input logic [4:0] idx, input logic [31:0] pc,
                                            input logic [31:0] instr);
        logic [7:0] b;
        b = ASCII_LF;
        if (idx == 5'd0) begin
            b = ASCII_P;
        end else if (idx <= 5'd8) begin
            b = hex_ascii(4'(pc >> (4 * (8 - 32'(idx)))));
        end else if (idx == 5'd9) begin
            b = ASCII_SP;
        end else if (idx == 5'd10) begin
            b = ASCII_I;
        end else if (idx <= 5'd18) begin
            b = hex_ascii(4'(instr >> (4 * (18 - 32'(idx)))));
        end else if (idx == 5'd19) begin
            b = ASCII_CR;
        end
        return b;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer with a per-bit baud counter; ready during the final stop-bit cycle.
module uart_tx_byte
    import fpga_debug_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       txd
);

    localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    logic                active_q, active_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [3:0]          bit_q, bit_d;
    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic                bit_end;

    assign bit_end  = (cnt_q == CntW'(CLKS_PER_BIT - 1));
    assign tx_ready = !active_q || (bit_end && (bit_q == 4'(FRAME_BITS - 1)));
    assign txd      = active_q ? shift_q[0] : 1'b1;

    always_comb begin
        active_d = active_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        if (tx_valid && tx_ready) begin
            active_d = 1'b1;
            cnt_d    = '0;
            bit_d    = '0;
            shift_d  = {1'b1, tx_data, 1'b0};
        end else if (active_q) begin
            if (bit_end) begin
                cnt_d = '0;
                if (bit_q == 4'(FRAME_BITS - 1)) begin
                    active_d = 1'b0;
                end else begin
                    bit_d   = bit_q + 4'd1;
                    shift_d = {1'b1, shift_q[FRAME_BITS-1:1]};
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '1;
        end else begin
            active_q <= active_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
        end
    end

endmodule

// File: rtl/uart_debug_tx.sv
// Snapshots PC/instruction on a trigger and streams them as one ASCII hex line over UART 8N1.
module uart_debug_tx
    import fpga_debug_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 100_000_000,
    parameter int unsigned BAUD        = 115_200,
    parameter int unsigned XLEN        = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            trigger,
    input  logic [XLEN-1:0] pc_in,
    input  logic [XLEN-1:0] instr_in,
    output logic            uart_txd,
    output logic            busy,
    output logic [7:0]      drop_count
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;

    if (CLKS_PER_BIT < 4) begin : g_baud_check
        $error("uart_debug_tx: CLKS_PER_BIT must be at least 4");
    end
    if (XLEN != 32) begin : g_xlen_check
        $error("uart_debug_tx: only XLEN=32 is supported");
    end

    line_state_e     state_q, state_d;
    logic [4:0]      idx_q, idx_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [7:0]      drop_q, drop_d;
    logic            tx_valid, tx_ready;
    logic [7:0]      tx_data;

    assign busy       = (state_q == StSend);
    assign drop_count = drop_q;
    // Index 0 is a constant 'P', so the first byte can launch on the trigger edge itself.
    assign tx_data    = msg_byte(idx_q, pc_q, instr_q);

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        drop_d   = drop_q;
        tx_valid = 1'b0;
        unique case (state_q)
            StIdle: begin
                tx_valid = trigger;
                if (trigger && tx_ready) begin
                    pc_d    = pc_in;
                    instr_d = instr_in;
                    idx_d   = 5'd1;
                    state_d = StSend;
                end
            end
            StSend: begin
                tx_valid = (idx_q < 5'(DBG_MSG_LEN));
                if (trigger && (drop_q != 8'hFF)) begin
                    drop_d = drop_q + 8'd1;
                end
                // With every byte handed off, the next ready marks the last stop-bit cycle.
                if (tx_ready) begin
                    if (tx_valid) begin
                        idx_d = idx_q + 5'd1;
                    end else begin
                        idx_d   = 5'd0;
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            idx_q   <= '0;
            pc_q    <= '0;
            instr_q <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            drop_q  <= drop_d;
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx_byte (
        .clk     (clk),
        .reset_n (reset_n),
        .tx_valid(tx_valid),
        .tx_data (tx_data),
        .tx_ready(tx_ready),
        .txd     (uart_txd)
    );

endmodule

// File: tb/tb_uart_debug_tx.sv
// Directed and randomized checks of uart_debug_tx against a line-level reference model.
module tb_uart_debug_tx;

    localparam int CPB  = 10;
    localparam int LINE = 21 * 10 * CPB;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        trigger;
    logic [31:0] pc_in;
    logic [31:0] instr_in;
    logic        uart_txd;
    logic        busy;
    logic [7:0]  drop_count;

    int vectors     = 0;
    int miscompares = 0;
    int exp_drop    = 0;
    logic [7:0] exp_line [21];

    always #5 clk = ~clk;

    uart_debug_tx #(
        .CLK_FREQ_HZ(1_000_000),
        .BAUD       (100_000),
        .XLEN       (32)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .trigger   (trigger),
        .pc_in     (pc_in),
        .instr_in  (instr_in),
        .uart_txd  (uart_txd),
        .busy      (busy),
        .drop_count(drop_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] hexc(input logic [3:0] n);
        string hx = "0123456789ABCDEF";
        return hx.getc(int'(n));
    endfunction

    function automatic void build_line(input logic [31:0] pc, input logic [31:0] instr);
        exp_line[0]  = 8'h50;
        exp_line[9]  = 8'h20;
        exp_line[10] = 8'h49;
        exp_line[19] = 8'h0D;
        exp_line[20] = 8'h0A;
        for (int k = 0; k < 8; k++) begin
            exp_line[1 + k]  = hexc(4'(pc >> (28 - 4 * k)));
            exp_line[11 + k] = hexc(4'(instr >> (28 - 4 * k)));
        end
    endfunction

    task automatic fire(input logic [31:0] pc, input logic [31:0] instr);
        @(negedge clk);
        pc_in    = pc;
        instr_in = instr;
        trigger  = 1'b1;
        build_line(pc, instr);
    endtask

    // Records one full line starting from its first start-bit cycle, then checks the gap cycle.
    task automatic capture(input bit hold, input int n_drops, input logic [31:0] next_pc,
                           input logic [31:0] next_instr, input bit again);
        logic       bits [LINE];
        int         busy_cnt = 0;
        int         unstable = 0;
        int         framing  = 0;
        logic [7:0] d;
        for (int i = 0; i < LINE; i++) begin
            @(negedge clk);
            bits[i] = uart_txd;
            if (busy === 1'b1) busy_cnt++;
            if (i == 0) check("busy_rise", busy, 1);
            if ((i % 150 == 0) || (i >= 253 && i <= 257)) check("drop_count", drop_count, exp_drop);
            trigger  = hold || (i >= 40 && i < 40 + n_drops);
            pc_in    = next_pc;
            instr_in = next_instr;
            if (trigger && busy === 1'b1) exp_drop = (exp_drop < 255) ? exp_drop + 1 : 255;
        end
        check("busy_cycles", busy_cnt, LINE);
        for (int b = 0; b < 21; b++) begin
            for (int k = 0; k < 10; k++)
                for (int c = 1; c < CPB; c++)
                    if (bits[b*100 + k*CPB + c] !== bits[b*100 + k*CPB]) unstable++;
            if (bits[b*100] !== 1'b0 || bits[b*100 + 9*CPB] !== 1'b1) framing++;
            for (int k = 0; k < 8; k++) d[k] = bits[b*100 + (k+1)*CPB + CPB/2];
            check($sformatf("byte%0d", b), d, exp_line[b]);
        end
        check("bit_stability", unstable, 0);
        check("framing", framing, 0);
        @(negedge clk);
        check("gap_busy", busy, 0);
        check("gap_txd", uart_txd, 1);
        check("gap_drop", drop_count, exp_drop);
        trigger = again;
    endtask

    initial begin
        logic [31:0] p, q;
        reset_n  = 1'b0;
        trigger  = 1'b0;
        pc_in    = '0;
        instr_in = '0;
        repeat (3) @(negedge clk);
        check("rst_txd", uart_txd, 1);
        check("rst_busy", busy, 0);
        check("rst_drop", drop_count, 0);
        reset_n = 1'b1;

        fire(32'h0000_1A3C, 32'h00A5_0513);
        capture(0, 0, 32'h0, 32'h0, 0);

        fire(32'hDEAD_BEEF, 32'h0000_0000);
        capture(0, 3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        check("drop_three", drop_count, 3);

        fire($urandom, $urandom);
        capture(0, 300, $urandom, $urandom, 0);
        check("drop_saturated", drop_count, 255);

        // Reset 700 cycles into a line.
        fire($urandom, $urandom);
        for (int i = 0; i < 700; i++) begin
            @(negedge clk);
            trigger = (i % 50 == 10);
        end
        reset_n = 1'b0;
        #1;
        check("midreset_txd", uart_txd, 1);
        check("midreset_busy", busy, 0);
        check("midreset_drop", drop_count, 0);
        exp_drop = 0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        trigger = 1'b0;
        fire($urandom, $urandom);
        capture(0, 0, $urandom, $urandom, 0);

        // Continuous trigger: two back-to-back lines.
        p = $urandom;
        q = $urandom;
        fire($urandom, $urandom);
        capture(1, 0, p, q, 1);
        build_line(p, q);
        capture(1, 0, $urandom, $urandom, 0);

        for (int n = 0; n < 3; n++) begin
            fire($urandom, $urandom);
            capture(0, $urandom_range(0, 5), $urandom, $urandom, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
